en_period_monitor: RTL

Checker for the periodic clock-enable strobes our enable generators feed into downstream logic (one strobe every 20 cycles of the 100 MHz `clk` in the current system). It measures the interval between strobe edges and flags strobes that arrive early or late. It also tracks lock to the expected rate and keeps error and pulse statistics. It sits next to each enable generator in the system, on the consuming side of the strobe, for bring-up and run-time health monitoring.

---
 rtl/en_period_monitor.sv | 186 ++++++++++++++++++
 1 files changed

// File: rtl/en_period_monitor.sv
`default_nettype none
// ============================================================================
//  Module      : en_period_monitor
//  Description : Health monitor for a periodic clock-enable strobe. Measures
//                the interval between 0->1 edges of en_in, flags intervals
//                that are too short (early_err) or missing strobes
//                (late_err), tracks lock to the expected rate and keeps
//                saturating error / wrapping pulse statistics.
//  Ports       : clk        - system clock
//                rst        - asynchronous active-low reset
//                en_in      - strobe under test (edge-detected)
//                clr        - synchronous clear of state and statistics
//                period     - last measured interval (CW bits)
//                period_vld - one-cycle pulse, period updated
//                early_err  - one-cycle pulse, interval too short
//                late_err   - one-cycle pulse, strobe overdue
//                locked     - level, monitor in LOCKED state
//                err_cnt    - early+late event count, saturates at 255
//                pulse_cnt  - strobe count, wraps at 2^16
//  Revision    : 1.0 - initial release
// ============================================================================
module en_period_monitor #(
    parameter int EXP_PERIOD = 20,
    parameter int TOL        = 1,
    parameter int LOCK_CNT   = 4,
    parameter int CW         = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          en_in,
    input  logic          clr,
    output logic [CW-1:0] period,
    output logic          period_vld,
    output logic          early_err,
    output logic          late_err,
    output logic          locked,
    output logic [7:0]    err_cnt,
    output logic [15:0]   pulse_cnt
);

    localparam int GW = $clog2(LOCK_CNT + 1);

    localparam logic [CW-1:0] c_GAP_LO   = CW'(EXP_PERIOD - TOL);
    localparam logic [CW-1:0] c_GAP_HI   = CW'(EXP_PERIOD + TOL);
    localparam logic [GW-1:0] c_LOCK_CNT = GW'(LOCK_CNT);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACQ    = 2'd1,
        S_LOCKED = 2'd2
    } state_t;

    state_t          r_state,      w_state_nxt;
    logic            r_en_d;
    logic [CW-1:0]   r_gap,        w_gap_nxt;
    logic [GW-1:0]   r_good_cnt,   w_good_cnt_nxt;
    logic            r_tmo,        w_tmo_nxt;
    logic [CW-1:0]   r_period,     w_period_nxt;
    logic            r_period_vld, w_period_vld_nxt;
    logic            r_early,      w_early_nxt;
    logic            r_late,       w_late_nxt;
    logic [7:0]      r_err_cnt,    w_err_cnt_nxt;
    logic [15:0]     r_pulse_cnt,  w_pulse_cnt_nxt;

    logic            w_pulse;
    logic [GW-1:0]   w_good_inc;
    logic [7:0]      w_err_inc;

    assign w_pulse    = en_in & ~r_en_d;
    assign w_good_inc = r_good_cnt + GW'(1);
    // Saturating increment shared by the early and late paths (they are
    // mutually exclusive: late requires the absence of a pulse).
    assign w_err_inc  = (r_err_cnt == 8'hFF) ? r_err_cnt : r_err_cnt + 8'd1;

    always_comb begin
        w_state_nxt      = r_state;
        w_good_cnt_nxt   = r_good_cnt;
        w_tmo_nxt        = r_tmo;
        w_period_nxt     = r_period;
        w_period_vld_nxt = 1'b0;
        w_early_nxt      = 1'b0;
        w_late_nxt       = 1'b0;
        w_err_cnt_nxt    = r_err_cnt;
        w_pulse_cnt_nxt  = r_pulse_cnt;

        if (w_pulse) begin
            w_gap_nxt = CW'(1);
        end else if (r_gap != {CW{1'b1}}) begin
            w_gap_nxt = r_gap + CW'(1);
        end else begin
            w_gap_nxt = r_gap;
        end

        if (clr) begin
            w_state_nxt     = S_IDLE;
            w_gap_nxt       = '0;
            w_good_cnt_nxt  = '0;
            w_tmo_nxt       = 1'b0;
            w_err_cnt_nxt   = '0;
            w_pulse_cnt_nxt = '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    // First edge only arms the monitor: no reference yet.
                    if (w_pulse) begin
                        w_state_nxt     = S_ACQ;
                        w_good_cnt_nxt  = '0;
                        w_pulse_cnt_nxt = r_pulse_cnt + 16'd1;
                    end
                end
                S_ACQ, S_LOCKED: begin
                    if (w_pulse) begin
                        w_period_nxt     = r_gap;
                        w_period_vld_nxt = 1'b1;
                        w_pulse_cnt_nxt  = r_pulse_cnt + 16'd1;
                        w_tmo_nxt        = 1'b0;
                        if (r_gap < c_GAP_LO) begin
                            w_early_nxt    = 1'b1;
                            w_err_cnt_nxt  = w_err_inc;
                            w_good_cnt_nxt = '0;
                            w_state_nxt    = S_ACQ;
                        end else if (r_gap <= c_GAP_HI) begin
                            if (r_state == S_ACQ) begin
                                w_good_cnt_nxt = w_good_inc;
                                if (w_good_inc == c_LOCK_CNT) begin
                                    w_state_nxt = S_LOCKED;
                                end
                            end
                        end else begin
                            // Overdue strobe: already reported by timeout.
                            w_good_cnt_nxt = '0;
                            w_state_nxt    = S_ACQ;
                        end
                    end else if ((r_gap == c_GAP_HI) && !r_tmo) begin
                        w_late_nxt     = 1'b1;
                        w_err_cnt_nxt  = w_err_inc;
                        w_tmo_nxt      = 1'b1;
                        w_good_cnt_nxt = '0;
                        w_state_nxt    = S_ACQ;
                    end
                end
                default: begin
                    w_state_nxt = S_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state      <= S_IDLE;
            r_en_d       <= 1'b0;
            r_gap        <= '0;
            r_good_cnt   <= '0;
            r_tmo        <= 1'b0;
            r_period     <= '0;
            r_period_vld <= 1'b0;
            r_early      <= 1'b0;
            r_late       <= 1'b0;
            r_err_cnt    <= '0;
            r_pulse_cnt  <= '0;
        end else begin
            r_state      <= w_state_nxt;
            r_en_d       <= en_in;
            r_gap        <= w_gap_nxt;
            r_good_cnt   <= w_good_cnt_nxt;
            r_tmo        <= w_tmo_nxt;
            r_period     <= w_period_nxt;
            r_period_vld <= w_period_vld_nxt;
            r_early      <= w_early_nxt;
            r_late       <= w_late_nxt;
            r_err_cnt    <= w_err_cnt_nxt;
            r_pulse_cnt  <= w_pulse_cnt_nxt;
        end
    end

    assign period     = r_period;
    assign period_vld = r_period_vld;
    assign early_err  = r_early;
    assign late_err   = r_late;
    assign locked     = (r_state == S_LOCKED);
    assign err_cnt    = r_err_cnt;
    assign pulse_cnt  = r_pulse_cnt;

endmodule
`default_nettype wire
